// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared opcodes, bubble instruction and state encoding for the IF/ID stage
package if_id_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    BUBBLE
  } state_t;

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return reads_rs1(op) && !(op == OP_IMM || op == OP_LOAD || op == OP_JALR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with stall/flush sequencing, watchdog and counters
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR   = if_id_stage_pkg::NOP_INSTR,
  parameter int          STALL_LIMIT = 8,
  parameter int          CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instruction_in,
  input  logic             nop,
  input  logic             flush,
  output logic             pcWrite,
  output logic [31:0]      IF_ID_pc,
  output logic [31:0]      IF_ID_instruction,
  output logic [6:0]       opCode,
  output logic [4:0]       IF_ID_rs1,
  output logic [4:0]       IF_ID_rs2,
  output logic [4:0]       IF_ID_rd,
  output logic             IF_ID_valid,
  output logic             stallTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  state_t           state, state_next;
  logic             load, bubble;
  logic [CNT_W-1:0] run_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A stall beats a flush: the branch decision seen while stalled is stale.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    bubble     = 1'b0;
    if (nop) begin
      state_next = HOLD;
    end else if (flush) begin
      state_next = BUBBLE;
      bubble     = 1'b1;
    end else begin
      state_next = RUN;
      load       = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      IF_ID_pc          <= '0;
      IF_ID_instruction <= NOP_INSTR;
      IF_ID_valid       <= 1'b0;
    end else if (load) begin
      IF_ID_pc          <= pc_in;
      IF_ID_instruction <= instruction_in;
      IF_ID_valid       <= 1'b1;
    end else if (bubble) begin
      IF_ID_pc          <= pc_in;
      IF_ID_instruction <= NOP_INSTR;
      IF_ID_valid       <= 1'b0;
    end
  end

  // Flag rises on the same edge the run counter reaches the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallTimeout <= 1'b0;
    end else if (nop && (run_count >= CNT_W'(STALL_LIMIT - 1))) begin
      stallTimeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (nop),
    .clr   (1'b0),
    .count (stallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (bubble),
    .clr   (1'b0),
    .count (flushCount)
  );

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (nop),
    .clr   (load),
    .count (run_count)
  );

  assign pcWrite   = reset | ~nop;
  assign opCode    = IF_ID_instruction[6:0];
  assign IF_ID_rd  = IF_ID_instruction[11:7];
  assign IF_ID_rs1 = (IF_ID_valid && reads_rs1(opCode)) ? IF_ID_instruction[19:15] : 5'd0;
  assign IF_ID_rs2 = (IF_ID_valid && reads_rs2(opCode)) ? IF_ID_instruction[24:20] : 5'd0;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instruction_in;
  logic        nop, flush;
  logic        pcWrite;
  logic [31:0] IF_ID_pc, IF_ID_instruction;
  logic [6:0]  opCode;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, IF_ID_rd;
  logic        IF_ID_valid, stallTimeout;
  logic [15:0] stallCount, flushCount;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  if_id_stage dut (
    .clock             (clock),
    .reset             (reset),
    .pc_in             (pc_in),
    .instruction_in    (instruction_in),
    .nop               (nop),
    .flush             (flush),
    .pcWrite           (pcWrite),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_instruction (IF_ID_instruction),
    .opCode            (opCode),
    .IF_ID_rs1         (IF_ID_rs1),
    .IF_ID_rs2         (IF_ID_rs2),
    .IF_ID_rd          (IF_ID_rd),
    .IF_ID_valid       (IF_ID_valid),
    .stallTimeout      (stallTimeout),
    .stallCount        (stallCount),
    .flushCount        (flushCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".pc"},    IF_ID_pc, 32'h0);
    chk({tag, ".ins"},   IF_ID_instruction, 32'h0000_0013);
    chk({tag, ".valid"}, 32'(IF_ID_valid), 32'd0);
    chk({tag, ".rs1"},   32'(IF_ID_rs1), 32'd0);
    chk({tag, ".rs2"},   32'(IF_ID_rs2), 32'd0);
    chk({tag, ".scnt"},  32'(stallCount), 32'd0);
    chk({tag, ".fcnt"},  32'(flushCount), 32'd0);
    chk({tag, ".tmo"},   32'(stallTimeout), 32'd0);
    chk({tag, ".pcw"},   32'(pcWrite), 32'd1);
    chk({tag, ".st"},    32'(dut.state), 32'(RUN));
  endtask

  initial begin
    reset = 1'b1; nop = 1'b0; flush = 1'b0;
    pc_in = 32'h100; instruction_in = 32'h0050_0093;
    step(); step();
    chk_reset_values("rst");

    reset = 1'b0;
    step();
    chk("ld0.pc", IF_ID_pc, 32'h100);
    chk("ld0.valid", 32'(IF_ID_valid), 32'd1);
    chk("ld0.op", 32'(opCode), 32'h13);
    chk("ld0.rs1", 32'(IF_ID_rs1), 32'd0);
    chk("ld0.rs2", 32'(IF_ID_rs2), 32'd0);
    chk("ld0.rd", 32'(IF_ID_rd), 32'd1);

    pc_in = 32'h104; instruction_in = 32'h0020_81B3;
    step();
    chk("add.rs1", 32'(IF_ID_rs1), 32'd1);
    chk("add.rs2", 32'(IF_ID_rs2), 32'd2);
    chk("add.rd", 32'(IF_ID_rd), 32'd3);

    nop = 1'b1; pc_in = 32'h108; instruction_in = 32'h0020_8463;
    #1 chk("stall.pcw", 32'(pcWrite), 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("stall.ins", IF_ID_instruction, 32'h0020_81B3);
    chk("stall.pc", IF_ID_pc, 32'h104);
    chk("stall.rs1", 32'(IF_ID_rs1), 32'd1);
    chk("stall.rs2", 32'(IF_ID_rs2), 32'd2);
    chk("stall.scnt", 32'(stallCount), 32'd3);
    chk("stall.st", 32'(dut.state), 32'(HOLD));

    nop = 1'b0;
    step();
    chk("rel.ins", IF_ID_instruction, 32'h0020_8463);
    chk("rel.pc", IF_ID_pc, 32'h108);
    chk("rel.op", 32'(opCode), 32'h63);
    chk("rel.st", 32'(dut.state), 32'(RUN));

    flush = 1'b1; pc_in = 32'h10C; instruction_in = 32'h1234_5678;
    step();
    chk("fl.ins", IF_ID_instruction, 32'h0000_0013);
    chk("fl.valid", 32'(IF_ID_valid), 32'd0);
    chk("fl.pc", IF_ID_pc, 32'h10C);
    chk("fl.rs1", 32'(IF_ID_rs1), 32'd0);
    chk("fl.rs2", 32'(IF_ID_rs2), 32'd0);
    chk("fl.fcnt", 32'(flushCount), 32'd1);
    chk("fl.st", 32'(dut.state), 32'(BUBBLE));

    nop = 1'b1; flush = 1'b1; pc_in = 32'h110;
    step();
    chk("nf.ins", IF_ID_instruction, 32'h0000_0013);
    chk("nf.pc", IF_ID_pc, 32'h10C);
    chk("nf.fcnt", 32'(flushCount), 32'd1);
    chk("nf.scnt", 32'(stallCount), 32'd4);
    chk("nf.st", 32'(dut.state), 32'(HOLD));

    nop = 1'b0; flush = 1'b0; pc_in = 32'h110; instruction_in = 32'h1234_50B7;
    step();
    chk("lui.rs1", 32'(IF_ID_rs1), 32'd0);
    chk("lui.rs2", 32'(IF_ID_rs2), 32'd0);
    pc_in = 32'h114; instruction_in = 32'h0051_0067;
    step();
    chk("jalr.rs1", 32'(IF_ID_rs1), 32'd2);
    chk("jalr.rs2", 32'(IF_ID_rs2), 32'd0);

    nop = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("wd7.tmo", 32'(stallTimeout), 32'd0);
    step();
    chk("wd8.tmo", 32'(stallTimeout), 32'd1);
    chk("wd8.scnt", 32'(stallCount), 32'd12);
    nop = 1'b0; pc_in = 32'h118; instruction_in = 32'h0050_0093;
    step();
    chk("wd.sticky", 32'(stallTimeout), 32'd1);
    chk("wd.ld", IF_ID_pc, 32'h118);

    nop = 1'b1;
    step();
    reset = 1'b1; flush = 1'b1;
    step();
    chk_reset_values("rhold");

    reset = 1'b0; flush = 1'b0; nop = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    chk("sat.scnt", 32'(stallCount), 32'h0000_FFFF);
    chk("sat.fcnt", 32'(flushCount), 32'd0);
    chk("sat.tmo", 32'(stallTimeout), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_values("rsat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
